// File: rtl/score_display.sv
// Four-digit multiplexed score display: two BCD digits per player, frame-coherent snapshot,
// registered active-low anode/cathode/decimal-point drive.
module score_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZB         = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] big1,
    input  logic [3:0] sm1,
    input  logic [3:0] big2,
    input  logic [3:0] sm2,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        SLOT_BIG1 = 2'd0,
        SLOT_SM1  = 2'd1,
        SLOT_BIG2 = 2'd2,
        SLOT_SM2  = 2'd3
    } slot_t;

    logic [CW-1:0] div_cnt;
    slot_t         idx;
    logic          tick;
    logic [3:0]    snap_big1, snap_sm1, snap_big2, snap_sm2;

    logic [3:0]    digit;
    logic          is_tens;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    always_comb tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt   <= '0;
            idx       <= SLOT_BIG1;
            snap_big1 <= '0;
            snap_sm1  <= '0;
            snap_big2 <= '0;
            snap_sm2  <= '0;
            an        <= '1;
            seg       <= '1;
            dp        <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + CW'(1);
            if (tick) begin
                idx <= slot_t'(idx + 2'd1);
            end
            // All four digits are latched together at frame wrap so a frame never mixes old and new scores.
            if (tick && idx == SLOT_SM2) begin
                snap_big1 <= big1;
                snap_sm1  <= sm1;
                snap_big2 <= big2;
                snap_sm2  <= sm2;
            end
            an  <= blank ? 4'b1111 : an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

    always_comb begin
        digit   = snap_big1;
        is_tens = 1'b1;
        an_next = 4'b0111;
        case (idx)
            SLOT_BIG1: begin digit = snap_big1; is_tens = 1'b1; an_next = 4'b0111; end
            SLOT_SM1:  begin digit = snap_sm1;  is_tens = 1'b0; an_next = 4'b1011; end
            SLOT_BIG2: begin digit = snap_big2; is_tens = 1'b1; an_next = 4'b1101; end
            SLOT_SM2:  begin digit = snap_sm2;  is_tens = 1'b0; an_next = 4'b1110; end
            default:   begin digit = snap_big1; is_tens = 1'b1; an_next = 4'b0111; end
        endcase
    end

    always_comb begin
        seg_next = 7'b0111111;
        case (digit)
            4'd0: seg_next = 7'b1000000;
            4'd1: seg_next = 7'b1111001;
            4'd2: seg_next = 7'b0100100;
            4'd3: seg_next = 7'b0110000;
            4'd4: seg_next = 7'b0011001;
            4'd5: seg_next = 7'b0010010;
            4'd6: seg_next = 7'b0000010;
            4'd7: seg_next = 7'b1111000;
            4'd8: seg_next = 7'b0000000;
            4'd9: seg_next = 7'b0010000;
            default: seg_next = 7'b0111111;
        endcase
        // Blanked leading zero keeps its anode active; only the cathodes go dark.
        if (LZB && is_tens && digit == 4'd0) begin
            seg_next = 7'b1111111;
        end
        dp_next = (idx != SLOT_SM1);
    end

endmodule
